// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller with a line-refill FSM.
// Lookup takes one cycle after the request; misses refill the whole line in word order 0..LINEWORDS-1.
module icache_ctrl #(
   parameter int LINES     = 16,
   parameter int LINEWORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instrreq,
   input  logic [31:0] instradr,
   output logic [31:0] instrF,
   output logic        hit,
   output logic        abort,
   input  logic        inval,
   output logic        memreq,
   output logic [31:0] memadr,
   input  logic [31:0] memrdata,
   input  logic        memready
);

   localparam int OFFW = $clog2(LINEWORDS);
   localparam int IDXW = $clog2(LINES);
   localparam int TAGW = 30 - OFFW - IDXW;
   localparam logic [OFFW-1:0] LAST_WORD = OFFW'(LINEWORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_REFILL = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [29:0]       r_wadr;
   logic [LINES-1:0]  r_valid;
   logic [TAGW-1:0]   r_tag [LINES];
   logic [31:0]       r_data [LINES*LINEWORDS];
   logic [OFFW-1:0]   r_cnt;
   logic              r_inval_pend;
   logic [31:0]       r_instr_hold;

   logic [TAGW-1:0]   w_tag;
   logic [IDXW-1:0]   w_idx;
   logic [OFFW-1:0]   w_off;
   logic              w_match;
   logic [31:0]       w_word;

   // Fields of the latched word address (byte offset bits are never stored).
   assign w_off   = r_wadr[OFFW-1:0];
   assign w_idx   = r_wadr[OFFW +: IDXW];
   assign w_tag   = r_wadr[29 -: TAGW];
   assign w_match = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_word  = r_data[{w_idx, w_off}];

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and output decode; instrF shows the held word unless a result is presented
   always_comb begin
      w_next = r_state;
      hit    = 1'b0;
      abort  = 1'b0;
      memreq = 1'b0;
      memadr = 32'd0;
      instrF = r_instr_hold;
      case (r_state)
         S_IDLE: begin
            if (instrreq) begin
               w_next = S_LOOKUP;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_LOOKUP: begin
            if (w_match) begin
               hit    = 1'b1;
               instrF = w_word;
               w_next = S_IDLE;
            end else begin
               abort  = 1'b1;
               w_next = S_REFILL;
            end
         end
         S_REFILL: begin
            abort  = 1'b1;
            memreq = 1'b1;
            memadr = {w_tag, w_idx, r_cnt, 2'b00};
            if (memready && (r_cnt == LAST_WORD)) begin
               w_next = S_DONE;
            end else begin
               w_next = S_REFILL;
            end
         end
         S_DONE: begin
            instrF = w_word;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Control state: address latch, valid bits, refill counter, pending invalidate, held word
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wadr       <= 30'd0;
         r_valid      <= '0;
         r_cnt        <= '0;
         r_inval_pend <= 1'b0;
         r_instr_hold <= 32'd0;
      end else begin
         r_instr_hold <= instrF;
         case (r_state)
            S_IDLE: begin
               if (instrreq) begin
                  r_wadr <= instradr[31:2];
               end
               if (inval) begin
                  r_valid <= '0;
               end
            end
            S_LOOKUP: begin
               // The hit decision above already used the pre-clear valid bits.
               if (inval) begin
                  r_valid <= '0;
               end else if (!w_match) begin
                  r_valid[w_idx] <= 1'b0;
               end
               if (!w_match) begin
                  r_cnt <= '0;
               end
            end
            S_REFILL: begin
               if (inval) begin
                  r_inval_pend <= 1'b1;
               end
               if (memready) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_cnt == LAST_WORD) begin
                     r_valid[w_idx] <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (inval || r_inval_pend) begin
                  r_valid <= '0;
               end
               r_inval_pend <= 1'b0;
            end
            default: begin
               r_inval_pend <= 1'b0;
            end
         endcase
      end
   end

   // Line storage; tag is committed with the last refill word
   always_ff @(posedge clk) begin
      if (!reset && (r_state == S_REFILL) && memready) begin
         r_data[{w_idx, r_cnt}] <= memrdata;
         if (r_cnt == LAST_WORD) begin
            r_tag[w_idx] <= w_tag;
         end
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: transaction-level cache model drives per-cycle expectations,
// one negedge process compares every output; literal checks pin refill addresses and fetched words.
module tb_icache_ctrl;

   localparam int LINES = 16;
   localparam int LW    = 4;
   localparam logic [31:0] LINE_BYTES = 32'd16;

   logic        clk = 1'b0;
   logic        reset, instrreq, inval, memready;
   logic [31:0] instradr, memrdata;
   logic [31:0] instrF, memadr;
   logic        hit, abort, memreq;

   logic [31:0] exp_instr, exp_memadr;
   logic        exp_hit, exp_abort, exp_memreq;
   bit          chk_en;
   int          n_cmp, n_err;
   logic [31:0] q_acc[$];

   bit          m_valid [LINES];
   logic [31:0] m_tag   [LINES];
   logic [31:0] m_last;

   always #5 clk = ~clk;

   icache_ctrl #(.LINES(LINES), .LINEWORDS(LW)) dut (
      .clk(clk), .reset(reset), .instrreq(instrreq), .instradr(instradr),
      .instrF(instrF), .hit(hit), .abort(abort), .inval(inval),
      .memreq(memreq), .memadr(memadr), .memrdata(memrdata), .memready(memready)
   );

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s at %0t: actual=%h required=%h", nm, $time, act, req);
      end
   endtask

   // Per-cycle comparison against the model's expectations
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("instrF", instrF, exp_instr);
         cmp("hit", 32'(hit), 32'(exp_hit));
         cmp("abort", 32'(abort), 32'(exp_abort));
         cmp("memreq", 32'(memreq), 32'(exp_memreq));
         if (exp_memreq) cmp("memadr", memadr, exp_memadr);
         if (memreq && memready) q_acc.push_back(memadr);
      end
   end

   function automatic int m_idx(input logic [31:0] a);
      return int'((a / LINE_BYTES) % LINES);
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] a);
      return a / (LINE_BYTES * LINES);
   endfunction

   function automatic logic [31:0] m_base(input logic [31:0] a);
      return a - (a % LINE_BYTES);
   endfunction

   task automatic clear_model();
      for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Idle drive with stray memready and garbage data to show they are ignored
   task automatic defaults();
      reset = 1'b0; instrreq = 1'b0; instradr = 32'h0000_0F00; inval = 1'b0;
      memready = 1'b1; memrdata = 32'hBAD0_BAD0;
      exp_hit = 1'b0; exp_abort = 1'b0; exp_memreq = 1'b0; exp_memadr = 32'd0;
      exp_instr = m_last;
   endtask

   // One fetch transaction; memory word at address A is A.
   // mode 0: memready always high; mode 1: high every third refill cycle.
   task automatic fetch(input logic [31:0] a, input int mode, input bit inv_idle,
                        input bit inv_lookup, input int inv_word, input int rst_word);
      int k, cyc, ix;
      bit rdy, pend, inv_sent;
      logic [31:0] base;
      ix = m_idx(a); base = m_base(a);
      defaults(); instrreq = 1'b1; instradr = a; inval = inv_idle;
      step();
      if (inv_idle) clear_model();
      defaults(); instrreq = 1'b1; inval = inv_lookup;
      if (m_valid[ix] && m_tag[ix] == m_tagof(a)) begin
         exp_hit = 1'b1; exp_instr = a & ~32'd3; m_last = exp_instr;
         step();
         if (inv_lookup) clear_model();
         return;
      end
      exp_abort = 1'b1;
      step();
      m_valid[ix] = 1'b0;
      if (inv_lookup) clear_model();
      k = 0; cyc = 0; pend = 1'b0; inv_sent = 1'b0;
      while (k < LW) begin
         defaults();
         instrreq = 1'b1;
         exp_abort = 1'b1; exp_memreq = 1'b1; exp_memadr = base + 32'(4 * k);
         if (k == rst_word) begin
            reset = 1'b1; memready = 1'b0;
            step();
            clear_model(); m_last = 32'd0;
            return;
         end
         if (k == inv_word && !inv_sent) begin
            inval = 1'b1; inv_sent = 1'b1; pend = 1'b1;
         end
         rdy = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
         memready = rdy;
         memrdata = rdy ? base + 32'(4 * k) : 32'hDEAD_BEEF;
         step();
         cyc++;
         if (rdy) k++;
      end
      defaults(); instrreq = 1'b1;
      exp_instr = a & ~32'd3; m_last = exp_instr;
      step();
      m_valid[ix] = 1'b1; m_tag[ix] = m_tagof(a);
      if (pend) clear_model();
   endtask

   task automatic check_acc(input string nm, input logic [31:0] base, input int n);
      cmp({nm, "_count"}, 32'(q_acc.size()), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (i < q_acc.size()) cmp({nm, "_adr"}, q_acc[i], base + 32'(4 * i));
      end
      q_acc.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_err = 0; chk_en = 1'b0;
      clear_model(); m_last = 32'd0;
      defaults(); reset = 1'b1;
      step(); step();
      defaults(); chk_en = 1'b1;
      step();
      q_acc.delete();

      // Cold miss
      fetch(32'h0000_0104, 0, 1'b0, 1'b0, -1, -1);
      check_acc("cold_refill", 32'h0000_0100, 4);
      cmp("cold_instr", instrF, 32'h0000_0104);
      // Warm hit, no memory traffic
      fetch(32'h0000_010C, 0, 1'b0, 1'b0, -1, -1);
      check_acc("warm_refill", 32'h0000_0100, 0);
      cmp("warm_instr", instrF, 32'h0000_010C);
      // Conflict on the same index
      fetch(32'h0000_1104, 0, 1'b0, 1'b0, -1, -1);
      check_acc("conflict_refill", 32'h0000_1100, 4);
      cmp("conflict_instr", instrF, 32'h0000_1104);
      fetch(32'h0000_0104, 0, 1'b0, 1'b0, -1, -1);
      check_acc("evicted_refill", 32'h0000_0100, 4);
      // Stalled memory
      fetch(32'h0000_0208, 1, 1'b0, 1'b0, -1, -1);
      check_acc("stall_refill", 32'h0000_0200, 4);
      cmp("stall_instr", instrF, 32'h0000_0208);
      // Invalidate during refill, then the same address misses
      fetch(32'h0000_030C, 0, 1'b0, 1'b0, 1, -1);
      check_acc("inval_refill", 32'h0000_0300, 4);
      cmp("inval_instr", instrF, 32'h0000_030C);
      fetch(32'h0000_030C, 0, 1'b0, 1'b0, -1, -1);
      check_acc("after_inval_refill", 32'h0000_0300, 4);
      // Reset after two refill words, then a complete refill from offset 0
      fetch(32'h0000_0404, 0, 1'b0, 1'b0, -1, 2);
      check_acc("rst_partial", 32'h0000_0400, 2);
      fetch(32'h0000_0404, 0, 1'b0, 1'b0, -1, -1);
      check_acc("rst_refill", 32'h0000_0400, 4);
      cmp("rst_instr", instrF, 32'h0000_0404);
      // Invalidate in IDLE alongside the request forces a miss
      fetch(32'h0000_0408, 0, 1'b1, 1'b0, -1, -1);
      check_acc("idle_inval_refill", 32'h0000_0400, 4);
      // Invalidate during a hitting LOOKUP: hit now, miss next time
      fetch(32'h0000_040C, 0, 1'b0, 1'b1, -1, -1);
      check_acc("lookup_inval_hit", 32'h0000_0400, 0);
      cmp("lookup_inval_instr", instrF, 32'h0000_040C);
      fetch(32'h0000_040C, 0, 1'b0, 1'b0, -1, -1);
      check_acc("lookup_inval_refill", 32'h0000_0400, 4);

      defaults();
      step();
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
